mem_arbiter: RTL and testbench

- Shares the single core memory port between two requesters:
  - the instruction side (fetchbuffer imem_in/imem_out);
  - the data side (load/store unit).
- Captures one request per requester and issues at most one transaction at a time to memory.
- Routes the response back to the requester that owns the transaction.
- Sits between the fetchbuffer/LSU and the memory/bus bridge.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between the fetch
// side and the load/store side; one transaction in flight at a time.

package mem_arb_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

endpackage

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       pend_i_q, pend_i_d;
  logic       pend_d_q, pend_d_d;
  mem_in_type req_i_q, req_i_d;
  mem_in_type req_d_q, req_d_d;
  mem_in_type mem_in_q, mem_in_d;
  logic       ptr_q, ptr_d;
  logic       gnt_d;
  logic       done;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pend_i_d = pend_i_q;
    pend_d_d = pend_d_q;
    req_i_d  = req_i_q;
    req_d_d  = req_d_q;
    ptr_d    = ptr_q;
    mem_in_d = '0;
    gnt_d    = 1'b0;
    done     = 1'b0;

    // A port holding a request ignores new valids until it completes
    if (imem_in.mem_valid && !pend_i_q) begin
      pend_i_d = 1'b1;
      req_i_d  = imem_in;
    end
    if (dmem_in.mem_valid && !pend_d_q) begin
      pend_d_d = 1'b1;
      req_d_d  = dmem_in;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_i_q || pend_d_q) begin
          if (pend_i_q && pend_d_q) begin
            if (ROUND_ROBIN) begin
              gnt_d = ptr_q;
              ptr_d = ~ptr_q;
            end else begin
              gnt_d = DATA_FIRST;
            end
          end else begin
            gnt_d = pend_d_q;
          end
          state_d  = ISSUE;
          owner_d  = gnt_d ? OWN_D : OWN_I;
          mem_in_d = gnt_d ? req_d_q : req_i_q;
        end
      end
      ISSUE: begin
        if (mem_out.mem_ready) begin
          done = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_out.mem_ready) begin
          done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      if (owner_q == OWN_I) begin
        pend_i_d = 1'b0;
      end
      if (owner_q == OWN_D) begin
        pend_d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      req_i_q  <= '0;
      req_d_q  <= '0;
      mem_in_q <= '0;
      ptr_q    <= DATA_FIRST;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      req_i_q  <= req_i_d;
      req_d_q  <= req_d_d;
      mem_in_q <= mem_in_d;
      ptr_q    <= ptr_d;
    end
  end

  assign mem_in = mem_in_q;

  always_comb begin
    imem_out = '0;
    dmem_out = '0;
    if (owner_q == OWN_I) begin
      imem_out = mem_out;
    end
    if (owner_q == OWN_D) begin
      dmem_out = mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic,
// compared each cycle against a transaction-level reference model.

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock;
  logic        reset;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;

  mem_arbiter #(
    .ROUND_ROBIN(1'b1),
    .DATA_FIRST (1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .imem_in (imem_in),
    .imem_out(imem_out),
    .dmem_in (dmem_in),
    .dmem_out(dmem_out),
    .mem_in  (mem_in),
    .mem_out (mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errs   = 0;
  int checks = 0;

  // reference model: index 0 = instruction side, 1 = data side
  mem_in_type m_req[2];
  bit         m_has[2];
  int         m_own;
  bit         m_iss;
  bit         m_ptr;

  mem_in_type  obs_mi;
  mem_out_type obs_io;
  mem_out_type obs_do;

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic mem_in_type mk(input logic [31:0] addr,
                                    input logic instr,
                                    input logic fence,
                                    input logic [31:0] wdata,
                                    input logic [3:0] wstrb);
    mem_in_type r;
    r           = '0;
    r.mem_valid = 1'b1;
    r.mem_fence = fence;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_in_type rnd_req(input logic instr);
    mem_in_type r;
    r           = '0;
    r.mem_valid = 1'b1;
    r.mem_fence = 1'($urandom_range(0, 1));
    r.mem_spec  = 1'($urandom_range(0, 1));
    r.mem_instr = instr;
    r.mem_addr  = $urandom();
    r.mem_wdata = $urandom();
    r.mem_wstrb = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic model_reset();
    m_has[0] = 1'b0;
    m_has[1] = 1'b0;
    m_req[0] = '0;
    m_req[1] = '0;
    m_own    = -1;
    m_iss    = 1'b0;
    m_ptr    = 1'b1;
  endtask

  task automatic step(input logic iv, input mem_in_type ir,
                      input logic dv, input mem_in_type dr,
                      input logic rdy, input logic [31:0] rd);
    mem_in_type  e_mi;
    mem_out_type e_io;
    mem_out_type e_do;
    bit          nh[2];
    mem_in_type  nr[2];
    int          w;
    @(negedge clock);
    reset             = 1'b1;
    imem_in           = ir;
    imem_in.mem_valid = iv;
    dmem_in           = dr;
    dmem_in.mem_valid = dv;
    mem_out.mem_ready = rdy;
    mem_out.mem_rdata = rd;
    #1;
    obs_mi = mem_in;
    obs_io = imem_out;
    obs_do = dmem_out;
    e_mi   = m_iss ? m_req[m_own] : '0;
    e_io   = '0;
    e_do   = '0;
    if (m_own == 0) begin
      e_io.mem_ready = rdy;
      e_io.mem_rdata = rd;
    end
    if (m_own == 1) begin
      e_do.mem_ready = rdy;
      e_do.mem_rdata = rd;
    end
    chk("mem_in", 80'(obs_mi), 80'(e_mi));
    chk("imem_out", 80'(obs_io), 80'(e_io));
    chk("dmem_out", 80'(obs_do), 80'(e_do));
    nh = m_has;
    nr = m_req;
    if (iv && !m_has[0]) begin
      nh[0] = 1'b1;
      nr[0] = imem_in;
    end
    if (dv && !m_has[1]) begin
      nh[1] = 1'b1;
      nr[1] = dmem_in;
    end
    if (m_own >= 0) begin
      if (rdy) begin
        nh[m_own] = 1'b0;
        m_own     = -1;
      end
      m_iss = 1'b0;
    end else if (m_has[0] || m_has[1]) begin
      if (m_has[0] && m_has[1]) begin
        w     = int'(m_ptr);
        m_ptr = ~m_ptr;
      end else begin
        w = m_has[1] ? 1 : 0;
      end
      m_own = w;
      m_iss = 1'b1;
    end
    m_has = nh;
    m_req = nr;
  endtask

  task automatic idle(input int n, input logic rdy, input logic [31:0] rd);
    for (int k = 0; k < n; k++) begin
      step(1'b0, '0, 1'b0, '0, rdy, rd);
    end
  endtask

  // reset is left asserted; the next step releases it
  task automatic rst_pulse();
    @(negedge clock);
    reset             = 1'b0;
    imem_in           = '0;
    dmem_in           = '0;
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_mem_in", 80'(mem_in), 80'd0);
    chk("rst_imem_out", 80'(imem_out), 80'd0);
    chk("rst_dmem_out", 80'(dmem_out), 80'd0);
    model_reset();
    @(posedge clock);
    #1;
    chk("rst_hold_mem_in", 80'(mem_in), 80'd0);
  endtask

  int n_iss;

  initial begin
    reset   = 1'b0;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_mem_in", 80'(mem_in), 80'd0);
    chk("reset_imem_out", 80'(imem_out), 80'd0);
    chk("reset_dmem_out", 80'(dmem_out), 80'd0);

    // single fetch, memory ready three cycles after issue
    step(1'b1, mk(32'h100, 1'b1, 1'b0, 32'h0, 4'h0), 1'b0, '0, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 0);
    chk("t1_valid", 80'(obs_mi.mem_valid), 80'd1);
    chk("t1_addr", 80'(obs_mi.mem_addr), 80'h100);
    chk("t1_instr", 80'(obs_mi.mem_instr), 80'd1);
    idle(2, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'h13);
    chk("t1_resp", 80'(obs_io), 80'({32'h13, 1'b1}));
    chk("t1_dready", 80'(obs_do.mem_ready), 80'd0);

    // tie: data first, then instruction; next tie goes to instruction
    step(1'b1, mk(32'h200, 1'b1, 1'b0, 32'h0, 4'h0),
         1'b1, mk(32'h8000, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'hF),
         1'b0, 0);
    idle(1, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 0);
    chk("t2_first", 80'(obs_mi.mem_addr), 80'h8000);
    chk("t2_wdata", 80'(obs_mi.mem_wdata), 80'hDEAD_BEEF);
    chk("t2_wstrb", 80'(obs_mi.mem_wstrb), 80'hF);
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'h55);
    idle(1, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'h66);
    chk("t2_second", 80'(obs_mi.mem_addr), 80'h200);
    step(1'b1, mk(32'h204, 1'b1, 1'b0, 32'h0, 4'h0),
         1'b1, mk(32'h8004, 1'b0, 1'b0, 32'h1, 4'h1),
         1'b0, 0);
    idle(1, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'h77);
    chk("t2_tie2", 80'(obs_mi.mem_addr), 80'h204);
    idle(1, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'h88);
    chk("t2_tie2_data", 80'(obs_mi.mem_addr), 80'h8004);

    // busy-port drop
    step(1'b0, '0, 1'b1, mk(32'h10, 1'b0, 1'b0, 32'h0, 4'h0), 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 0);
    step(1'b0, '0, 1'b1, mk(32'h14, 1'b0, 1'b0, 32'h0, 4'h0), 1'b0, 0);
    chk("t3_addr", 80'(obs_mi.mem_addr), 80'h10);
    step(1'b0, '0, 1'b1, mk(32'h14, 1'b0, 1'b0, 32'h0, 4'h0), 1'b1, 1);
    idle(3, 1'b0, 0);
    chk("t3_no_issue", 80'(obs_mi.mem_valid), 80'd0);

    // zero-wait memory with both sides always requesting
    n_iss = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, rnd_req(1'b1), 1'b1, rnd_req(1'b0), 1'b1, $urandom());
      if (obs_mi.mem_valid) n_iss++;
    end
    chk("t4_issues", 80'(n_iss), 80'd5);
    idle(4, 1'b1, 0);

    // reset during a wait owned by the instruction side
    step(1'b1, mk(32'h300, 1'b1, 1'b0, 32'h0, 4'h0), 1'b0, '0, 1'b0, 0);
    idle(3, 1'b0, 0);
    rst_pulse();
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'hABCD);
    chk("t5_iready", 80'(obs_io.mem_ready), 80'd0);
    chk("t5_dready", 80'(obs_do.mem_ready), 80'd0);
    idle(3, 1'b1, 32'h1);
    chk("t5_no_valid", 80'(obs_mi.mem_valid), 80'd0);

    // fence forwarding
    step(1'b1, mk(32'h400, 1'b1, 1'b1, 32'h0, 4'h0), 1'b0, '0, 1'b0, 0);
    idle(1, 1'b0, 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 0);
    chk("t6_fence", 80'(obs_mi.mem_fence), 80'd1);
    chk("t6_addr", 80'(obs_mi.mem_addr), 80'h400);
    step(1'b0, '0, 1'b0, '0, 1'b1, 32'h99);
    chk("t6_ready", 80'(obs_io.mem_ready), 80'd1);

    // random traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_pulse();
      end else begin
        step(1'($urandom_range(0, 1)), rnd_req(1'b1),
             1'($urandom_range(0, 1)), rnd_req(1'b0),
             ($urandom_range(0, 2) == 0), $urandom());
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
